// File: rtl/hazard_scoreboard.sv
// Decode-side hazard tracking: stall, per-operand forwarding select, mispredict flush, stage nop flags.
// Latency: all outputs are combinational from decode inputs and the tracked stage state; stage state moves every edge.
// Backpressure: stall holds decode and injects a bubble into stage 1; stages 2..NSTAGES always advance.
module hazard_scoreboard #(
    parameter int REGNOBITS = 4,
    parameter int NSTAGES   = 3,
    parameter int LDSTAGE   = 2,
    parameter int FWD_EN    = 1,
    parameter int SELBITS   = 2,
    parameter int CNTBITS   = 16
) (
    input  logic                 clk,
    input  logic                 RESET_N,
    input  logic                 valid_D,
    input  logic                 use_rs_D,
    input  logic                 use_rt_D,
    input  logic [REGNOBITS-1:0] rs_D,
    input  logic [REGNOBITS-1:0] rt_D,
    input  logic                 wrreg_D,
    input  logic [REGNOBITS-1:0] destreg_D,
    input  logic                 ldmem_D,
    input  logic                 mispred_A,
    input  logic                 clr_cnt,
    output logic                 stall,
    output logic                 flush_D,
    output logic [SELBITS-1:0]   fwd_rs_sel,
    output logic [SELBITS-1:0]   fwd_rt_sel,
    output logic [NSTAGES-1:0]   isnop_S,
    output logic [CNTBITS-1:0]   stall_cnt,
    output logic [CNTBITS-1:0]   flush_cnt
);

    // Result of searching the tracked stages for the youngest writer of a register.
    typedef struct packed {
        logic               hit;
        logic               ld;
        logic [SELBITS-1:0] k;
    } res_t;

    // Index 0 is stage 1 (ALU/AGEN), index NSTAGES-1 is writeback.
    logic [NSTAGES-1:0]   valid_q;
    logic [NSTAGES-1:0]   wr_q;
    logic [NSTAGES-1:0]   ld_q;
    logic [REGNOBITS-1:0] dest_q [NSTAGES];

    res_t res_rs;
    res_t res_rt;
    logic hazard_rs;
    logic hazard_rt;
    logic load_d;

    // Scan oldest to youngest so the youngest matching writer is the one left standing.
    function automatic res_t lookup(input logic [REGNOBITS-1:0] s);
        res_t r;
        r = '0;
        for (int k = NSTAGES; k >= 1; k--) begin
            if (valid_q[k-1] && wr_q[k-1] && (dest_q[k-1] == s)) begin
                r.hit = 1'b1;
                r.ld  = ld_q[k-1];
                r.k   = SELBITS'(k);
            end
        end
        return r;
    endfunction

    // A match is a hazard when forwarding is off or a load result is not yet available.
    function automatic logic is_hazard(input res_t r);
        return r.hit && ((FWD_EN == 0) || (r.ld && (int'(r.k) < LDSTAGE)));
    endfunction

    // Operand resolution, stall and flush decisions.
    always_comb begin
        res_rs     = lookup(rs_D);
        res_rt     = lookup(rt_D);
        hazard_rs  = use_rs_D && is_hazard(res_rs);
        hazard_rt  = use_rt_D && is_hazard(res_rt);
        fwd_rs_sel = (use_rs_D && res_rs.hit && !hazard_rs) ? res_rs.k : '0;
        fwd_rt_sel = (use_rt_D && res_rt.hit && !hazard_rt) ? res_rt.k : '0;
        // A mispredict only matters if there is a real instruction in stage 1 to have resolved it.
        flush_D    = mispred_A && valid_q[0];
        stall      = valid_D && !flush_D && (hazard_rs || hazard_rt);
        load_d     = valid_D && !stall && !flush_D;
        isnop_S    = ~valid_q;
    end

    // Stage pipeline: stage 1 takes decode or a bubble, the rest shift unconditionally.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= '0;
            wr_q    <= '0;
            ld_q    <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                dest_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= load_d;
            wr_q[0]    <= wrreg_D;
            ld_q[0]    <= ldmem_D;
            dest_q[0]  <= destreg_D;
            for (int k = 1; k < NSTAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                wr_q[k]    <= wr_q[k-1];
                ld_q[k]    <= ld_q[k-1];
                dest_q[k]  <= dest_q[k-1];
            end
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_D && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard over three configurations sharing one stimulus.
// Expected values are queued as stimulus is applied and popped when outputs are sampled.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic       valid_D, use_rs_D, use_rt_D, wrreg_D, ldmem_D, mispred_A, clr_cnt;
    logic [3:0] rs_D, rt_D, destreg_D;

    // u0: defaults (forwarding on)
    logic        u0_stall, u0_flush;
    logic [1:0]  u0_rs_sel, u0_rt_sel;
    logic [2:0]  u0_isnop;
    logic [15:0] u0_stall_cnt, u0_flush_cnt;
    // u1: forwarding disabled
    logic        u1_stall, u1_flush;
    logic [1:0]  u1_rs_sel, u1_rt_sel;
    logic [2:0]  u1_isnop;
    logic [15:0] u1_stall_cnt, u1_flush_cnt;
    // u2: five stages, forwarding disabled, 2-bit counters
    logic        u2_stall, u2_flush;
    logic [2:0]  u2_rs_sel, u2_rt_sel;
    logic [4:0]  u2_isnop;
    logic [1:0]  u2_stall_cnt, u2_flush_cnt;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard u0 (
        .clk(clk), .RESET_N(RESET_N), .valid_D(valid_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .rs_D(rs_D), .rt_D(rt_D), .wrreg_D(wrreg_D), .destreg_D(destreg_D), .ldmem_D(ldmem_D),
        .mispred_A(mispred_A), .clr_cnt(clr_cnt), .stall(u0_stall), .flush_D(u0_flush),
        .fwd_rs_sel(u0_rs_sel), .fwd_rt_sel(u0_rt_sel), .isnop_S(u0_isnop),
        .stall_cnt(u0_stall_cnt), .flush_cnt(u0_flush_cnt)
    );

    hazard_scoreboard #(.FWD_EN(0)) u1 (
        .clk(clk), .RESET_N(RESET_N), .valid_D(valid_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .rs_D(rs_D), .rt_D(rt_D), .wrreg_D(wrreg_D), .destreg_D(destreg_D), .ldmem_D(ldmem_D),
        .mispred_A(mispred_A), .clr_cnt(clr_cnt), .stall(u1_stall), .flush_D(u1_flush),
        .fwd_rs_sel(u1_rs_sel), .fwd_rt_sel(u1_rt_sel), .isnop_S(u1_isnop),
        .stall_cnt(u1_stall_cnt), .flush_cnt(u1_flush_cnt)
    );

    hazard_scoreboard #(.NSTAGES(5), .SELBITS(3), .FWD_EN(0), .CNTBITS(2)) u2 (
        .clk(clk), .RESET_N(RESET_N), .valid_D(valid_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .rs_D(rs_D), .rt_D(rt_D), .wrreg_D(wrreg_D), .destreg_D(destreg_D), .ldmem_D(ldmem_D),
        .mispred_A(mispred_A), .clr_cnt(clr_cnt), .stall(u2_stall), .flush_D(u2_flush),
        .fwd_rs_sel(u2_rs_sel), .fwd_rt_sel(u2_rt_sel), .isnop_S(u2_isnop),
        .stall_cnt(u2_stall_cnt), .flush_cnt(u2_flush_cnt)
    );

    task automatic ex(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic drive(input logic v, input logic urs, input logic urt, input logic [3:0] rs,
                         input logic [3:0] rt, input logic wr, input logic [3:0] dst, input logic ld);
        valid_D   = v;
        use_rs_D  = urs;
        use_rt_D  = urt;
        rs_D      = rs;
        rt_D      = rt;
        wrreg_D   = wr;
        destreg_D = dst;
        ldmem_D   = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        RESET_N   = 1'b0;
        mispred_A = 1'b0;
        clr_cnt   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        RESET_N = 1'b1;
        #1;
    endtask

    initial begin
        RESET_N   = 1'b0;
        mispred_A = 1'b0;
        clr_cnt   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        // Reset state
        ex(0); ex(0); ex(3'b111); ex(0); ex(0); ex(0); ex(0);
        chk("rst_stall", 32'(u0_stall));
        chk("rst_flush", 32'(u0_flush));
        chk("rst_isnop", 32'(u0_isnop));
        chk("rst_rs_sel", 32'(u0_rs_sel));
        chk("rst_rt_sel", 32'(u0_rt_sel));
        chk("rst_stall_cnt", 32'(u0_stall_cnt));
        chk("rst_flush_cnt", 32'(u0_flush_cnt));
        @(negedge clk);
        RESET_N = 1'b1;
        #1;

        // ALU then use: forward from stage 1, then stage 2
        drive(1, 0, 0, 0, 0, 1, 3, 0);
        tick();
        drive(1, 1, 0, 3, 0, 0, 0, 0);
        ex(0); ex(1);
        chk("alu_use_stall", 32'(u0_stall));
        chk("alu_use_sel1", 32'(u0_rs_sel));
        tick();
        ex(0); ex(2);
        chk("alu_use_stall2", 32'(u0_stall));
        chk("alu_use_sel2", 32'(u0_rs_sel));

        // Load-use: one stall cycle then forward from stage 2
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 1);
        tick();
        drive(1, 0, 1, 0, 5, 0, 0, 0);
        ex(1);
        chk("lduse_stall_c0", 32'(u0_stall));
        tick();
        ex(0); ex(2); ex(1); ex(1);
        chk("lduse_stall_c1", 32'(u0_stall));
        chk("lduse_rt_sel", 32'(u0_rt_sel));
        chk("lduse_bubble", 32'(u0_isnop[0]));
        chk("lduse_stall_cnt", 32'(u0_stall_cnt));

        // Youngest writer hides the older one
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 2, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 2, 0);
        tick();
        drive(1, 1, 1, 2, 2, 0, 0, 0);
        ex(1); ex(1); ex(0);
        chk("young_rs_sel", 32'(u0_rs_sel));
        chk("young_rt_sel", 32'(u0_rt_sel));
        chk("young_stall", 32'(u0_stall));

        // Same, but the youngest writer is a load: stall rather than stage-3 forward
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 2, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 2, 1);
        tick();
        drive(1, 1, 1, 2, 2, 0, 0, 0);
        ex(1);
        chk("young_ld_stall", 32'(u0_stall));

        // Mispredict overrides a pending load-use stall
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 1);
        tick();
        mispred_A = 1'b1;
        drive(1, 0, 1, 0, 5, 0, 0, 0);
        ex(1); ex(0);
        chk("mispred_flush", 32'(u0_flush));
        chk("mispred_stall", 32'(u0_stall));
        tick();
        mispred_A = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ex(3'b101); ex(1); ex(0);
        chk("mispred_isnop", 32'(u0_isnop));
        chk("mispred_flush_cnt", 32'(u0_flush_cnt));
        chk("mispred_stall_cnt", 32'(u0_stall_cnt));

        // Forwarding disabled: stall while the writer is in any of the 3 stages
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 7, 0);
        tick();
        drive(1, 1, 0, 7, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ex((i < 3) ? 32'd1 : 32'd0);
            chk("nofwd_stall", 32'(u1_stall));
            if (i < 3) tick();
        end
        ex(0); ex(3);
        chk("nofwd_sel", 32'(u1_rs_sel));
        chk("nofwd_stall_cnt", 32'(u1_stall_cnt));

        // Saturation: 5-cycle stall on a 2-bit counter
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 4, 0);
        tick();
        drive(1, 1, 0, 4, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            ex(1);
            chk("sat_stall", 32'(u2_stall));
            tick();
        end
        ex(0); ex(3);
        chk("sat_stall_end", 32'(u2_stall));
        chk("sat_stall_cnt", 32'(u2_stall_cnt));

        // Asynchronous reset in the middle of a stall
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 4, 0);
        tick();
        drive(1, 1, 0, 4, 0, 0, 0, 0);
        tick();
        ex(1); ex(1);
        chk("arst_pre_stall", 32'(u2_stall));
        chk("arst_pre_cnt", 32'(u2_stall_cnt));
        RESET_N = 1'b0;
        #1;
        ex(0); ex(5'h1f); ex(0); ex(0); ex(0);
        chk("arst_stall", 32'(u2_stall));
        chk("arst_isnop", 32'(u2_isnop));
        chk("arst_stall_cnt", 32'(u2_stall_cnt));
        chk("arst_flush", 32'(u2_flush));
        chk("arst_rs_sel", 32'(u2_rs_sel));
        @(negedge clk);
        RESET_N = 1'b1;
        #1;

        // Counter clear wins over a concurrent stall increment
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 4, 0);
        tick();
        drive(1, 1, 0, 4, 0, 0, 0, 0);
        tick();
        tick();
        ex(1); ex(2);
        chk("clr_pre_stall", 32'(u2_stall));
        chk("clr_pre_cnt", 32'(u2_stall_cnt));
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        #1;
        ex(1); ex(0);
        chk("clr_stall", 32'(u2_stall));
        chk("clr_stall_cnt", 32'(u2_stall_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline.
- Tracks the destination register of every in-flight instruction beyond decode, over a configurable number of stages.
- Produces the decode stall, the per-operand forwarding source select, the decode flush on branch mispredict, and the per-stage nop flags.
- Keeps saturating stall and flush performance counters.
- Sits beside the decode stage. It replaces the fixed two-stage rs/rt compare-and-stall logic.

Parameters:
REGNOBITS, 4, register number width
NSTAGES, 3, tracked stages after decode (stage 1 = ALU/AGEN, stage NSTAGES = writeback)
LDSTAGE, 2, first stage whose load result is forwardable; must satisfy 1 <= LDSTAGE <= NSTAGES
FWD_EN, 1, 1 = forwarding enabled; 0 = stall on any dependency
SELBITS, 2, select width; must satisfy 2^SELBITS > NSTAGES
CNTBITS, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
valid_D  in  1  decode holds a real instruction
use_rs_D  in  1  instruction reads rs
use_rt_D  in  1  instruction reads rt
rs_D  in  REGNOBITS  source register 1
rt_D  in  REGNOBITS  source register 2
wrreg_D  in  1  instruction writes a register
destreg_D  in  REGNOBITS  destination register
ldmem_D  in  1  instruction is a load
mispred_A  in  1  stage-1 instruction resolved as mispredicted
clr_cnt  in  1  synchronous counter clear
stall  out  1  hold PC and decode; insert bubble into stage 1
flush_D  out  1  kill the decode instruction
fwd_rs_sel  out  SELBITS  0 = register file, k = forward from stage k
fwd_rt_sel  out  SELBITS  same encoding, for rt
isnop_S  out  NSTAGES  bit k-1 = stage k holds a bubble
stall_cnt  out  CNTBITS  cycles with stall=1
flush_cnt  out  CNTBITS  cycles with flush_D=1

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (RESET_N).
- Reset state: all stage valid bits 0 and counters 0.
  - Resulting outputs: isnop_S all 1, stall 0, flush_D 0, fwd selects 0.
  - Reset asserted mid-operation takes effect immediately and discards all in-flight state.
- Per-stage state (k = 1..NSTAGES): valid_k, wr_k, ld_k, dest_k.
- Shift on every rising edge. There is no back-pressure from stages 2..NSTAGES.
  - Stage 1 loads the decode entry {valid_D, wrreg_D, ldmem_D, destreg_D} only when valid_D=1, stall=0 and flush_D=1 is false. Otherwise stage 1 loads a bubble (valid=0).
  - Stage k loads stage k-1 for k = 2..NSTAGES.
  - The stage NSTAGES entry retires. The register file write happens at the end of that cycle, and the file is read next cycle.
- flush_D = mispred_A & valid_1, combinational. A mispred with stage 1 empty is ignored. The stage-1 instruction itself is not killed.
- Source resolution is combinational and runs for each operand s in {rs, rt} whose use bit is 1.
  - Find the lowest k with valid_k & wr_k & (dest_k == s). The youngest writer wins and hides older ones.
  - No match: sel = 0, no hazard.
  - Match with FWD_EN=0: hazard.
  - Match with ld_k=1 and k < LDSTAGE: hazard.
  - Otherwise: sel = k.
  - Unused operand: sel = 0.
- stall = valid_D & ~flush_D & (hazard_rs | hazard_rt). Flush overrides stall.
- While stall=1, the fwd selects still reflect the current resolution. The consumer ignores them.
- Counters:
  - stall_cnt increments when stall=1; flush_cnt increments when flush_D=1.
  - Both saturate at all-ones and do not wrap.
  - clr_cnt=1 zeroes both next edge, with priority over increment.
- No special zero register: every register number is tracked.

Test Plan (defaults unless stated):
1. ALU then use: stage 1 = {wr, dest=3}; decode reads rs=3 -> stall=0, fwd_rs_sel=1. Next cycle the writer is in stage 2 -> sel=2.
2. Load-use: stage 1 = {wr, ld, dest=5}; decode reads rt=5.
   - Cycle 0: stall=1.
   - Cycle 1: stall=0, fwd_rt_sel=2, isnop_S[0]=1.
   - stall_cnt=1.
3. Youngest wins: stage 1 dest=2, stage 3 dest=2; decode rs=2, rt=2 -> both sels=1. With a load in stage 1 instead -> stall, not sel=3.
4. Mispred: valid_1=1, mispred_A=1, decode has a dependent load-use -> flush_D=1, stall=0. Next cycle isnop_S[0]=1; flush_cnt=1.
5. FWD_EN=0: ALU writer dest=7 enters stage 1; decode reads rs=7 -> stall for exactly 3 cycles, then sel=0; stall_cnt=3.
6. Reset/saturation: CNTBITS=2, hold a hazard for 5 cycles -> stall_cnt=3. Then pulse RESET_N low mid-stall -> all outputs at reset values immediately. Separately, clr_cnt with stall=1 -> 0.
